// File: rtl/frame_stack.sv
// frame_stack: LIFO data stack with hardware call frames.
// CALL opens a frame whose base becomes the pop/replace underflow limit;
// RETURN drops the whole frame in one cycle and restores the caller's base.
// Optional feature macro: FRAME_STACK_PEEK_EN (adds a registered peek port).
// Ports:
//   clk, reset       clock; synchronous active-low reset (priority over op)
//   op[2:0]          0 NONE, 1 PUSH, 2 POP, 3 REPLACE, 4 CALL, 5 RETURN
//   data[WIDTH]      value for PUSH / REPLACE
//   tos[WIDTH]       registered top-of-stack value
//   status[1:0]      0 NONE, 1 EMPTY, 2 UNDERFLOW, 3 OVERFLOW
//   index            current entry count, 0..2^DEPTH
//   frame_base       base index of the current frame
//   frame_count      number of open frames, 0..2^FDEPTH
//   peek_offset/peek_data/peek_valid (FRAME_STACK_PEEK_EN only)
module frame_stack #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  tos,
  output logic [1:0]        status,
  output logic [DEPTH:0]    index,
  output logic [DEPTH:0]    frame_base,
  output logic [FDEPTH:0]   frame_count
`ifdef FRAME_STACK_PEEK_EN
  ,
  input  logic [DEPTH-1:0]  peek_offset,
  output logic [WIDTH-1:0]  peek_data,
  output logic              peek_valid
`endif
);

  localparam int unsigned ENTRIES = 1 << DEPTH;
  localparam int unsigned FRAMES  = 1 << FDEPTH;

  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_CALL    = 3'd4;
  localparam logic [2:0] OP_RETURN  = 3'd5;

  localparam logic [1:0] ST_NONE  = 2'd0;
  localparam logic [1:0] ST_EMPTY = 2'd1;
  localparam logic [1:0] ST_UNDER = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [DEPTH:0]   fb  [FRAMES];

  logic [DEPTH:0]   index_n;
  logic [DEPTH:0]   base_n;
  logic [FDEPTH:0]  count_n;
  logic [WIDTH-1:0] tos_n;
  logic [1:0]       status_n;
  logic             err;
  logic [1:0]       err_code;
  logic             mem_we;
  logic [DEPTH-1:0] mem_waddr;
  logic             fb_we;

  // Address helpers; only used when the guarding condition holds, so wrap is harmless.
  logic [DEPTH-1:0]  top_addr;
  logic [DEPTH-1:0]  below_addr;
  logic [DEPTH-1:0]  base_top_addr;
  logic [FDEPTH-1:0] fb_waddr;
  logic [FDEPTH-1:0] fb_raddr;

  always_comb begin
    top_addr      = index[DEPTH-1:0] - DEPTH'(1);
    below_addr    = index[DEPTH-1:0] - DEPTH'(2);
    base_top_addr = frame_base[DEPTH-1:0] - DEPTH'(1);
    fb_waddr      = frame_count[FDEPTH-1:0];
    fb_raddr      = frame_count[FDEPTH-1:0] - FDEPTH'(1);
  end

  // Next-state decode for one op per cycle.
  always_comb begin
    index_n   = index;
    base_n    = frame_base;
    count_n   = frame_count;
    tos_n     = tos;
    err       = 1'b0;
    err_code  = ST_NONE;
    mem_we    = 1'b0;
    mem_waddr = index[DEPTH-1:0];
    fb_we     = 1'b0;
    case (op)
      OP_PUSH: begin
        if (index == (DEPTH+1)'(ENTRIES)) begin
          err      = 1'b1;
          err_code = ST_OVER;
        end else begin
          mem_we  = 1'b1;
          index_n = index + (DEPTH+1)'(1);
          tos_n   = data;
        end
      end
      OP_POP: begin
        if (index == frame_base) begin
          err      = 1'b1;
          err_code = ST_UNDER;
        end else begin
          index_n = index - (DEPTH+1)'(1);
          if (index >= (DEPTH+1)'(2)) tos_n = mem[below_addr];
        end
      end
      OP_REPLACE: begin
        if (index == frame_base) begin
          err      = 1'b1;
          err_code = ST_UNDER;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = top_addr;
          tos_n     = data;
        end
      end
      OP_CALL: begin
        if (frame_count == (FDEPTH+1)'(FRAMES)) begin
          err      = 1'b1;
          err_code = ST_OVER;
        end else begin
          fb_we   = 1'b1;
          base_n  = index;
          count_n = frame_count + (FDEPTH+1)'(1);
        end
      end
      OP_RETURN: begin
        if (frame_count == '0) begin
          err      = 1'b1;
          err_code = ST_UNDER;
        end else begin
          index_n = frame_base;
          base_n  = fb[fb_raddr];
          count_n = frame_count - (FDEPTH+1)'(1);
          if (frame_base != '0) tos_n = mem[base_top_addr];
        end
      end
      default: ;
    endcase
    if (err)                   status_n = err_code;
    else if (index_n == base_n) status_n = ST_EMPTY;
    else                       status_n = ST_NONE;
  end

`ifdef FRAME_STACK_PEEK_EN
  logic [DEPTH-1:0] peek_addr;
  logic [WIDTH-1:0] peek_word;
  logic             peek_in_frame;

  // Peek tracks the post-op index; forward a same-cycle write to the peeked slot.
  always_comb begin
    peek_addr     = index_n[DEPTH-1:0] - DEPTH'(1) - peek_offset;
    peek_word     = (mem_we && (mem_waddr == peek_addr)) ? data : mem[peek_addr];
    peek_in_frame = {1'b0, index_n} >=
                    ({1'b0, base_n} + (DEPTH+2)'(1) + (DEPTH+2)'(peek_offset));
  end
`endif

  // Control/status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      index       <= '0;
      frame_base  <= '0;
      frame_count <= '0;
      tos         <= '0;
      status      <= ST_EMPTY;
`ifdef FRAME_STACK_PEEK_EN
      peek_data   <= '0;
      peek_valid  <= 1'b0;
`endif
    end else begin
      index       <= index_n;
      frame_base  <= base_n;
      frame_count <= count_n;
      tos         <= tos_n;
      status      <= status_n;
`ifdef FRAME_STACK_PEEK_EN
      peek_data   <= peek_word;
      peek_valid  <= peek_in_frame;
`endif
    end
  end

  // Storage arrays are not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[mem_waddr] <= data;
    if (reset && fb_we)  fb[fb_waddr]   <= frame_base;
  end

endmodule
